// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM encoding
// and the sub-word store merge used by the read-modify-write path.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_e;

    // Overlay the store's low byte or halfword onto the word read from memory.
    function automatic logic [XLEN-1:0] merge_word(input logic [2:0]      funct3,
                                                   input logic [XLEN-1:0] old_word,
                                                   input logic [XLEN-1:0] store_data);
        logic [XLEN-1:0] merged;
        merged = old_word;
        if (funct3 == F3_B) begin
            merged = {old_word[31:8], store_data[7:0]};
        end else if (funct3 == F3_H) begin
            merged = {old_word[31:16], store_data[15:0]};
        end
        return merged;
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Combinational load formatter: selects and sign/zero-extends the low byte,
// halfword or full word of the memory read data according to funct3.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] rdata,
    output logic        bad
);

    always_comb begin
        rdata = '0;
        bad   = 1'b0;
        case (funct3)
            F3_B:    rdata = {{24{word[7]}}, word[7:0]};
            F3_BU:   rdata = {24'h0, word[7:0]};
            F3_H:    rdata = {{16{word[15]}}, word[15:0]};
            F3_HU:   rdata = {16'h0, word[15:0]};
            F3_W:    rdata = word;
            default: bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-write data memory; sub-word stores use a
// two-cycle read-modify-write. Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             req_valid_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             stall_o,
    output logic             err_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             mem_write_o,
    output logic             mem_read_o,
    input  logic [31:0]      mem_rdata_i,
    output logic [CNT_W-1:0] rmw_cnt_o
);

    // The word port always touches four bytes, so the last legal address is DEPTH-4.
    localparam logic [31:0] ADDR_MAX = 32'(DEPTH - 4);

    lsu_state_e       state_q;
    lsu_state_e       state_d;
    logic [31:0]      cap_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cap_en;
    logic             cnt_en;

    logic [31:0] fmt_rdata;
    logic        fmt_bad;
    logic        range_fault;
    logic        width_fault;
    logic        misalign;
    logic        fault;
    logic        sub_store;

    lsu_load_fmt u_fmt (
        .funct3 (funct3_i),
        .word   (mem_rdata_i),
        .rdata  (fmt_rdata),
        .bad    (fmt_bad)
    );

    always_comb begin
        range_fault = addr_i > ADDR_MAX;
        width_fault = (is_load_i && fmt_bad) ||
                      (is_store_i && !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W));
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((funct3_i == F3_H || funct3_i == F3_HU) && addr_i[0]) ||
                   ((funct3_i == F3_W) && (addr_i[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        fault = req_valid_i && (is_load_i || is_store_i) &&
                ((is_load_i && is_store_i) || range_fault || width_fault || misalign);
        sub_store = (funct3_i == F3_B) || (funct3_i == F3_H);
    end

    always_comb begin
        state_d     = state_q;
        cap_en      = 1'b0;
        cnt_en      = 1'b0;
        rdata_o     = '0;
        stall_o     = 1'b0;
        err_o       = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fault) begin
                    err_o = 1'b1;
                end else if (req_valid_i && is_load_i) begin
                    mem_read_o = 1'b1;
                    mem_addr_o = addr_i;
                    rdata_o    = fmt_rdata;
                end else if (req_valid_i && is_store_i) begin
                    mem_addr_o = addr_i;
                    if (sub_store) begin
                        // First half of the RMW: fetch the surrounding word and hold the pipe.
                        mem_read_o = 1'b1;
                        stall_o    = 1'b1;
                        cap_en     = 1'b1;
                        state_d    = RMW_WR;
                    end else begin
                        mem_write_o = 1'b1;
                        mem_wdata_o = wdata_i;
                    end
                end
            end
            RMW_WR: begin
                mem_addr_o  = addr_i;
                mem_write_o = 1'b1;
                mem_wdata_o = merge_word(funct3_i, cap_q, wdata_i);
                cnt_en      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Nothing reaches the memory or the pipeline while reset is held.
        if (reset) begin
            rdata_o     = '0;
            stall_o     = 1'b0;
            err_o       = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
            mem_write_o = 1'b0;
            mem_read_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            cap_q <= '0;
            cnt_q <= '0;
        end else begin
            if (cap_en) begin
                cap_q <= mem_rdata_i;
            end
            if (cnt_en) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign rmw_cnt_o = cnt_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: a byte-array data memory, a byte-level
// reference model, a directed vector table, hand RMW/reset sequences and random ops.
module tb_lsu_rmw;

    localparam int DEPTH = 32;
    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             reset;
    logic             req_valid_i;
    logic             is_load_i;
    logic             is_store_i;
    logic [2:0]       funct3_i;
    logic [31:0]      addr_i;
    logic [31:0]      wdata_i;
    logic [31:0]      rdata_o;
    logic             stall_o;
    logic             err_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             mem_write_o;
    logic             mem_read_o;
    logic [31:0]      mem_rdata_i;
    logic [CNT_W-1:0] rmw_cnt_o;

    lsu_rmw #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .is_load_i   (is_load_i),
        .is_store_i  (is_store_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_write_o (mem_write_o),
        .mem_read_o  (mem_read_o),
        .mem_rdata_i (mem_rdata_i),
        .rmw_cnt_o   (rmw_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Data memory: byte array, combinational 4-byte read, whole-word write.
    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    always_comb begin
        mem_rdata_i = '0;
        for (int k = 0; k < 4; k++) begin
            if (int'(mem_addr_o) + k < DEPTH) begin
                mem_rdata_i[8*k +: 8] = mem[int'(mem_addr_o) + k];
            end
        end
    end

    always @(posedge clk_i) begin
        if (mem_write_o) begin
            for (int k = 0; k < 4; k++) begin
                if (int'(mem_addr_o) + k < DEPTH) begin
                    mem[int'(mem_addr_o) + k] <= mem_wdata_o[8*k +: 8];
                end
            end
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [DEPTH];
    int         exp_cnt;
    int         total;
    int         bad;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        stall;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        wr2;
        logic [31:0] wd2;
        logic        stall2;
    } obs_t;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_stall;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic ref_fault(input logic ld, input logic st, input logic [2:0] f3,
                                       input logic [31:0] a);
        logic f;
        f = 1'b0;
        if (ld && st) f = 1'b1;
        if (a > 32'(DEPTH - 4)) f = 1'b1;
        if (ld && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) f = 1'b1;
        if (st && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) f = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) f = 1'b1;
        if (f3 == 3'd2 && (a % 4 != 0)) f = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        int v;
        case (f3)
            3'd0: begin v = int'(ref_mem[a]); if (v > 127) v -= 256; end
            3'd4: v = int'(ref_mem[a]);
            3'd1: begin v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]); if (v > 32767) v -= 65536; end
            3'd5: v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]);
            default: return ref_word(a);
        endcase
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[a+k] = wd[8*k +: 8];
        if (n < 4) exp_cnt++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the access has fully retired.
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, output obs_t o);
        req_valid_i = 1'b1;
        is_load_i   = ld;
        is_store_i  = st;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        #4;
        o.rdata  = rdata_o;
        o.err    = err_o;
        o.stall  = stall_o;
        o.rd     = mem_read_o;
        o.wr     = mem_write_o;
        o.wdata  = mem_wdata_o;
        o.wr2    = 1'b0;
        o.wd2    = '0;
        o.stall2 = 1'b0;
        if (stall_o) begin
            @(posedge clk_i);
            #4;
            o.wr2    = mem_write_o;
            o.wd2    = mem_wdata_o;
            o.stall2 = stall_o;
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        is_load_i   = 1'b0;
        is_store_i  = 1'b0;
    endtask

    vec_t vt[12];
    obs_t o;

    initial begin
        total = 0;
        bad = 0;
        exp_cnt = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

        // Reset: hold a valid load request and confirm everything is quiet.
        reset = 1'b1;
        req_valid_i = 1'b1;
        is_load_i = 1'b1;
        is_store_i = 1'b0;
        funct3_i = 3'd2;
        addr_i = 32'd8;
        wdata_i = '0;
        repeat (2) @(posedge clk_i);
        #3;
        chk("rst_read", {31'd0, mem_read_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_cnt", 32'(rmw_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        req_valid_i = 1'b0;
        #3;
        chk("idle_ctrl", {28'd0, mem_read_o, mem_write_o, stall_o, err_o}, 32'd0);
        chk("idle_addr", mem_addr_o, 32'd0);
        @(posedge clk_i);
        #1;

        vt[0]  = '{1'b0, 1'b1, 3'd2, 32'd8,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 3'd2, 32'd8,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 3'd0, 32'd8,  32'h0,        32'hFFFFFFEF, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 3'd4, 32'd8,  32'h0,        32'h000000EF, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 3'd1, 32'd8,  32'h0,        32'hFFFFBEEF, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 3'd5, 32'd8,  32'h0,        32'h0000BEEF, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 3'd2, 32'd12, 32'hAABBCCDD, 32'h0,        1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 3'd2, 32'd29, 32'h0,        32'h0,        1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 3'd3, 32'd0,  32'h0,        32'h0,        1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 3'd2, 32'd0,  32'h0,        32'h0,        1'b1, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
        vt[10] = '{1'b1, 1'b0, 3'd1, 32'd9,  32'h0,        32'h0,        1'b1, 1'b0};
`else
        vt[10] = '{1'b1, 1'b0, 3'd1, 32'd9,  32'h0,        32'hFFFFADBE, 1'b0, 1'b0};
`endif
        vt[11] = '{1'b1, 1'b0, 3'd0, 32'd28, 32'h0,        32'h0,        1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            do_op(vt[i].ld, vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, o);
            chk($sformatf("vec%0d_err", i), {31'd0, o.err}, {31'd0, vt[i].exp_err});
            chk($sformatf("vec%0d_rdata", i), o.rdata, vt[i].exp_rd);
            chk($sformatf("vec%0d_stall", i), {31'd0, o.stall}, {31'd0, vt[i].exp_stall});
            if (vt[i].exp_err) begin
                chk($sformatf("vec%0d_suppress", i), {30'd0, o.rd, o.wr}, 32'd0);
            end
            if (vt[i].st && !vt[i].exp_err) begin
                chk($sformatf("vec%0d_sw", i), o.wdata, vt[i].wd);
                ref_store(vt[i].f3, int'(vt[i].a), vt[i].wd);
            end
        end

        // SB 0x55 @8 read-modify-write.
        do_op(1'b0, 1'b1, 3'd0, 32'd8, 32'h00000055, o);
        chk("sb_c1", {29'd0, o.stall, o.rd, o.wr}, 32'b110);
        chk("sb_c2", {30'd0, o.wr2, o.stall2}, 32'b10);
        chk("sb_wdata", o.wd2, 32'hDEADBE55);
        ref_store(3'd0, 8, 32'h55);
        chk("sb_cnt", 32'(rmw_cnt_o), 32'd1);
        do_op(1'b1, 1'b0, 3'd2, 32'd8, 32'h0, o);
        chk("sb_readback", o.rdata, 32'hDEADBE55);

        // SH 0x1234 @12 over 0xAABBCCDD.
        do_op(1'b0, 1'b1, 3'd1, 32'd12, 32'hFFFF1234, o);
        chk("sh_wdata", o.wd2, 32'hAABB1234);
        ref_store(3'd1, 12, 32'h1234);
        chk("sh_cnt", 32'(rmw_cnt_o), 32'd2);

        // Second SH, reset asserted while in the write cycle.
        req_valid_i = 1'b1;
        is_load_i = 1'b0;
        is_store_i = 1'b1;
        funct3_i = 3'd1;
        addr_i = 32'd12;
        wdata_i = 32'h00009999;
        #4;
        chk("rst_rmw_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i);
        #1;
        reset = 1'b1;
        #3;
        chk("rst_rmw_nowrite", {31'd0, mem_write_o}, 32'd0);
        chk("rst_rmw_cnt", 32'(rmw_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        req_valid_i = 1'b0;
        is_store_i = 1'b0;
        exp_cnt = 0;
        @(posedge clk_i);
        #1;
        do_op(1'b1, 1'b0, 3'd2, 32'd12, 32'h0, o);
        chk("rst_rmw_mem", o.rdata, 32'hAABB1234);

        // SB at the last legal address.
        do_op(1'b0, 1'b1, 3'd0, 32'd28, 32'h00000077, o);
        chk("sb28_err", {31'd0, o.err}, 32'd0);
        chk("sb28_stall", {31'd0, o.stall}, 32'd1);
        chk("sb28_wdata", o.wd2, 32'h00000077);
        ref_store(3'd0, 28, 32'h77);

        // Randomized operations against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic        ld;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            logic        f;
            ld = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = (ld && $urandom_range(0, 1) == 1) ? 3'd4 + 3'($urandom_range(0, 1))
                                                                                      : 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, DEPTH + 1));
            wd = $urandom;
            f = ref_fault(ld, !ld, f3, a);
            do_op(ld, !ld, f3, a, wd, o);
            chk($sformatf("rnd%0d_err", n), {31'd0, o.err}, {31'd0, f});
            if (f) begin
                chk($sformatf("rnd%0d_suppress", n), {29'd0, o.rd, o.wr, o.stall}, 32'd0);
                chk($sformatf("rnd%0d_rdata0", n), o.rdata, 32'd0);
            end else if (ld) begin
                chk($sformatf("rnd%0d_load", n), o.rdata, ref_load(f3, int'(a)));
            end else begin
                ref_store(f3, int'(a), wd);
                if (f3 == 3'd2) begin
                    chk($sformatf("rnd%0d_sw", n), {o.wr, o.stall, o.wdata[29:0]},
                        {1'b1, 1'b0, ref_word(int'(a))[29:0]});
                end else begin
                    chk($sformatf("rnd%0d_rmw", n), o.wd2, ref_word(int'(a)));
                    chk($sformatf("rnd%0d_rmw_ctl", n), {30'd0, o.stall, o.wr2}, 32'b11);
                end
            end
        end

        chk("final_cnt", 32'(rmw_cnt_o), 32'(exp_cnt));
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("final_mem%0d", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit that sits directly upstream of the data memory. It is the only agent driving the memory's address, write data, write enable and read enable.
- The data memory is byte-addressed, 32-bit wide, unaligned-capable, and writes whole words only. This block adds LB/LH/LW/LBU/LHU load formatting and SB/SH/SW stores.
- Sub-word stores use a 2-cycle read-modify-write (RMW), during which the pipeline is stalled.

Parameters:
- DEPTH, 32, memory size in bytes; the legal address limit.
- CNT_W, 16, width of the RMW event counter.

Ports:
- clk_i  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  1  MEM-stage access valid
- is_load_i  in  1  access is a load
- is_store_i  in  1  access is a store
- funct3_i  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  32  byte address
- wdata_i  in  32  store data
- rdata_o  out  32  formatted load result
- stall_o  out  1  hold the pipeline; request inputs must stay stable while high
- err_o  out  1  access fault; the access is suppressed
- mem_addr_o  out  32  to data memory
- mem_wdata_o  out  32  to data memory
- mem_write_o  out  1  to data memory
- mem_read_o  out  1  to data memory
- mem_rdata_i  in  32  from data memory; combinational read of bytes addr..addr+3
- rmw_cnt_o  out  CNT_W  count of completed RMW stores

Behaviour:
- Reset (async, active-high):
  - state=IDLE, captured word=0, rmw_cnt_o=0.
  - All combinational outputs fall to 0 while reset is asserted.
- States: IDLE, RMW_WR.
- Range check: fault when addr_i > DEPTH-4, for every width. The memory's word port always touches 4 bytes, so all widths need this margin.
  - On fault: err_o=1, mem_write_o=0, mem_read_o=0, rdata_o=0, stall_o=0, no state change.
  - err_o is combinational and valid only while req_valid_i=1.
- IDLE, load (req_valid_i & is_load_i, no fault):
  - mem_read_o=1, mem_addr_o=addr_i.
  - rdata_o is available the same cycle (0 latency):
    - B: sign-extend byte [7:0]; BU: zero-extend [7:0].
    - H: sign-extend [15:0]; HU: zero-extend [15:0].
    - W: [31:0].
  - Any other funct3 value: err_o=1, rdata_o=0.
- IDLE, SW: mem_write_o=1, mem_wdata_o=wdata_i, mem_addr_o=addr_i, no stall.
- IDLE, SB/SH:
  - mem_read_o=1, stall_o=1.
  - Capture mem_rdata_i on the clock edge, then go to RMW_WR.
- RMW_WR:
  - mem_addr_o=addr_i, mem_write_o=1, stall_o=0.
  - mem_wdata_o = captured word with [7:0] replaced by wdata_i[7:0] (SB), or [15:0] replaced by wdata_i[15:0] (SH).
  - Next state IDLE; rmw_cnt_o increments and wraps at 2^CNT_W-1 → 0.
- is_load_i & is_store_i both high: treated as a fault (err_o=1, suppressed).
- req_valid_i=0 in IDLE: all memory controls 0, mem_addr_o=0, rdata_o=0.
- Reset during RMW_WR: return to IDLE; no write is issued and the counter is cleared.
- Back-to-back: the next request is accepted in the cycle after RMW_WR. There is no request lost or duplicated.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misalignment is a fault, handled exactly like a range fault (err_o=1, access suppressed):
  - H/HU/SH with addr_i[0]=1.
  - W/SW with addr_i[1:0]≠0.
- Undefined: unaligned accesses proceed normally, since the memory port supports them.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The state encoding IDLE/RMW_WR.
  - Width constants.
- One natural sub-module: lsu_load_fmt, a combinational extractor/extender (funct3 + word → rdata).
- The FSM, merge logic, fault checks and counter stay in lsu_rmw.

Test Plan:
- SW 0xDEADBEEF @8, then LW @8 → mem_write_o for one cycle, no stall; rdata_o=0xDEADBEEF.
- With word 0xDEADBEEF @8:
  - LB @8 → rdata_o=0xFFFFFFEF.
  - LBU @8 → 0x000000EF.
  - LH @8 → 0xFFFFBEEF.
  - LHU @8 → 0x0000BEEF.
- SB 0x55 @8:
  - Cycle 1: stall_o=1, mem_read_o=1.
  - Cycle 2: mem_write_o=1, mem_wdata_o=0xDEADBE55.
  - rmw_cnt_o=1; a following LW @8 returns 0xDEADBE55.
- SH 0x1234 @12 over 0xAABBCCDD → 0xAABB1234. Assert reset in RMW_WR on a second SH → no write, memory unchanged, counter=0.
- LW @29 (DEPTH=32) → err_o=1, mem_read_o=0, rdata_o=0. SB @28 → accepted.
- LSU_MISALIGN_TRAP_EN defined: LH @9 → err_o=1. Undefined: LH @9 → no err, rdata_o = sign-extended bytes 9..10.
